// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch PC generator.
package pc_pkg;

   typedef enum logic {
      BOOT,
      RUN
   } pc_state_e;

   localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] PC_TRAP_VEC  = 32'h0000_0100;
   localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] push_data_i,
   output logic [XLEN-1:0] top_o,
   output logic            empty_o,
   output logic            full_o
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] stack_q [RAS_DEPTH];
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            empty_q, full_q;
   logic            wr_en;
   logic [PtrW-1:0] wr_idx;

   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = ptr_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (push_i && pop_i && !empty_q) begin
         // Return consumes the top while the call replaces it: depth unchanged.
         wr_en = 1'b1;
      end else if (push_i) begin
         ptr_d  = ptr_q + 1'b1;
         wr_en  = 1'b1;
         wr_idx = ptr_d;
         if (cnt_q != CntW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop_i && !empty_q) begin
         ptr_d = ptr_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q   <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         empty_q <= (cnt_d == '0);
         full_q  <= (cnt_d == CntW'(RAS_DEPTH));
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         stack_q[wr_idx] <= push_data_i;
      end
   end

   assign top_o   = stack_q[ptr_q];
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with trap/redirect/hold priority and an optional
// return-address stack built only when PC_GEN_RAS_EN is defined.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC),
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC),
   parameter int unsigned     INC       = PC_INC,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_hold,
   input  logic            trap,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            ras_push,
   input  logic            ras_pop,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC) - XLEN'(1));

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] ras_top;
   logic            run;
   logic            ras_ok, ras_push_en, ras_pop_en, ras_clear;

   assign run    = (state_q == RUN);
   assign pc_inc = pc_q + XLEN'(INC);

   // Stack only moves on a plain sequential fetch.
   assign ras_ok      = run && !trap && !redirect_valid && !pc_hold;
   assign ras_push_en = ras_ok && ras_push;
   assign ras_pop_en  = ras_ok && ras_pop;
   assign ras_clear   = run && trap;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            state_d = RUN;
            if (trap) begin
               pc_d = TRAP_VEC;
            end else if (redirect_valid) begin
               pc_d = redirect_pc & ALIGN_MASK;
            end else if (pc_hold) begin
               pc_d = pc_q;
            end else if (ras_pop && !ras_empty) begin
               pc_d = ras_top;
            end else begin
               pc_d = pc_inc;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_VEC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

`ifdef PC_GEN_RAS_EN
   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (ras_clear),
      .push_i      (ras_push_en),
      .pop_i       (ras_pop_en),
      .push_data_i (pc_inc),
      .top_o       (ras_top),
      .empty_o     (ras_empty),
      .full_o      (ras_full)
   );
`else
   logic unused_ras;
   assign unused_ras = ras_push_en ^ ras_pop_en ^ ras_clear;
   assign ras_top    = '0;
   assign ras_empty  = 1'b1;
   assign ras_full   = 1'b0;
`endif

   assign pc       = pc_q;
   assign pc_valid = run;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the PC width.
REQ-002 The parameter RESET_VEC SHALL default to 32'h0000_0000 and set the PC value loaded by reset.
REQ-003 The parameter TRAP_VEC SHALL default to 32'h0000_0100 and set the PC value loaded on trap.
REQ-004 The parameter INC SHALL default to 4 and set the sequential increment, a power of two.
REQ-005 The parameter RAS_DEPTH SHALL default to 4 and set the number of return-address-stack entries, a power of two, 2 or more.
REQ-006 The port list SHALL be, in order:
- clk  in  1  clock; rising edge only.
- rst  in  1  synchronous active-high reset.
- pc_hold  in  1  1 = hold PC (stall), 0 = advance.
- trap  in  1  take trap to TRAP_VEC.
- redirect_valid  in  1  branch/jump resolved taken.
- redirect_pc  in  XLEN  redirect target.
- ras_push  in  1  current fetch is a call; push pc+INC.
- ras_pop  in  1  current fetch is a return; predict from stack top.
- pc  out  XLEN  current fetch PC.
- pc_valid  out  1  pc is a valid fetch address.
- ras_empty  out  1  stack holds no entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset.

Function
REQ-008 The FSM SHALL have the states BOOT and RUN; reset enters BOOT, BOOT moves to RUN unconditionally after one cycle, and RUN holds until reset.
REQ-009 In BOOT, pc SHALL equal RESET_VEC and pc_valid SHALL be 0; in RUN, pc_valid SHALL be 1.
REQ-010 In RUN, the next pc SHALL be selected at each rising edge by strict priority: trap -> TRAP_VEC; redirect_valid -> redirect_pc; pc_hold -> pc; ras_pop with stack non-empty -> stack top; otherwise pc+INC.
REQ-011 Before loading redirect_pc, the block SHALL clear its low log2(INC) bits.
REQ-012 The sum pc+INC SHALL wrap modulo 2^XLEN with no flag.
REQ-013 Every pc change SHALL take effect one cycle after the inputs are sampled; no input SHALL reach pc combinationally.
REQ-014 ras_push and ras_pop SHALL act only in RUN, when trap, redirect_valid and pc_hold are all 0.
REQ-015 A push SHALL write pc+INC above the current top; on a push when full, the oldest entry SHALL be overwritten (circular) and the count SHALL stay at RAS_DEPTH.
REQ-016 A pop when empty SHALL be ignored: pc advances by INC and the stack is unchanged.
REQ-017 On a simultaneous push and pop, next pc SHALL be the old top and the top entry SHALL be replaced with pc+INC, with the count unchanged (or pc+INC pushed if empty).
REQ-018 A trap SHALL empty the stack; a redirect SHALL leave the stack unchanged.
REQ-019 ras_empty and ras_full SHALL be registered outputs that reflect the count after the last edge.

Reset
REQ-020 While rst=1 at an edge: pc=RESET_VEC, pc_valid=0, state=BOOT, stack count=0, ras_empty=1, ras_full=0; all other inputs SHALL be ignored.
REQ-021 A reset asserted mid-operation SHALL override trap, redirect and stack activity in the same cycle.

Configuration
REQ-022 With macro PC_GEN_RAS_EN defined, the return-address stack of REQ-014..REQ-019 SHALL be built.
REQ-023 Without PC_GEN_RAS_EN: no stack storage SHALL be built; ras_push and ras_pop SHALL be ignored; ras_empty SHALL be 1 and ras_full SHALL be 0; the port list SHALL be unchanged.

Structure
REQ-024 A shared package pc_pkg SHALL hold the FSM state typedef (BOOT, RUN) and the default RESET_VEC, TRAP_VEC and INC constants.
REQ-025 The return-address stack SHALL be a sub-module pc_ras (parameters XLEN and RAS_DEPTH) with push, pop, push data, top, empty, full and clear.

Verification
REQ-026 Reset, then release with all inputs 0 -> one cycle pc=0 with pc_valid=0, then pc=0, 4, 8, ... with pc_valid=1.
REQ-027 pc_hold=1 for 3 cycles at pc=0x10 -> pc stays 0x10 for 3 cycles, then 0x14.
REQ-028 trap=1, redirect_valid=1 and redirect_pc=0x200 in the same cycle -> next pc=0x100 and ras_empty=1; redirect_pc=0x203 alone -> next pc=0x200.
REQ-029 RAS_DEPTH=4: five pushes at pc=0x0, 0x4, 0x8, 0xC, 0x10, then five pops -> return targets 0x14, 0x10, 0xC, 0x8, then sequential pc+4 (empty); ras_full is 1 after the 4th push.
REQ-030 XLEN=32, pc=0xFFFF_FFFC with no events -> next pc=0x0000_0000.
REQ-031 rst=1 asserted during a pop with ras_full=1 -> pc=RESET_VEC, ras_empty=1, state=BOOT; without PC_GEN_RAS_EN, ras_pop=1 -> pc advances by 4 and ras_empty stays 1.
